time_set_editor: RTL and testbench
==================================

# time_set_editor

Cursor-driven editor that builds the 8-digit display string and the blink-cursor index for the downstream digit scanner/blinker. In SHOW it mirrors the running time; in EDIT it holds a shadow copy the user steps digit by digit, then commits it to the timekeeper with a one-cycle load pulse. It sits between the debounced button logic and timekeeper upstream and the display scanner downstream.

## Interface
- TIMEOUT_CYCLES, default 32'd500_000_000: idle cycles in EDIT before auto-abort; used only with the macro.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  one-cycle pulse, already debounced; enter/commit.
- btn_left / btn_right  in  1  one-cycle pulses; move cursor.
- btn_inc / btn_dec  in  1  one-cycle pulses; step digit under cursor.
- time_in  in  24  running time, BCD, {H1,H0,M1,M0,S1,S0}.
- string  out  32  display nibbles, [31:28] = digit 7 … [3:0] = digit 0.
- count_8  out  5  cursor digit index 0–7; 8 = no cursor.
- edit  out  1  high while in EDIT.
- load  out  1  one-cycle commit strobe.
- time_out  out  24  committed BCD time; valid when load is high, held afterwards.

## Operation
- Display layout, digits 7..0: H1 H0 DASH M1 M0 DASH S1 S0. DASH = 4'hb, BLANK = 4'ha.
- States:
  - SHOW: string from time_in; count_8 = 8; edit = 0.
  - EDIT: string from the shadow registers; count_8 = cursor; edit = 1.
  - COMMIT: one cycle; load = 1; time_out = shadow.
- Transitions:
  - SHOW -> EDIT on btn_mode. The shadow captures time_in that cycle, and the cursor is set to 7.
  - EDIT -> COMMIT on btn_mode.
  - COMMIT -> SHOW unconditionally.
- Cursor movement:
  - Valid positions are {7,6,4,3,1,0}. Positions 5 and 2 are always skipped.
  - btn_right moves 7→6→4→3→1→0→7.
  - btn_left moves in the reverse order.
- Digit limits:
  - H1 0–2.
  - H0 0–9, or 0–3 when H1 = 2.
  - M1 and S1 0–5.
  - M0 and S0 0–9.
- Digit stepping:
  - btn_inc at the limit wraps to 0.
  - btn_dec at 0 wraps to the limit.
  - Any change that makes H1 = 2 while H0 > 3 forces H0 to 3 in the same cycle.
- Input priority in a single cycle: btn_mode > btn_left/btn_right > btn_inc/btn_dec.
  - Only the highest-priority class acts.
  - left+right together do nothing, as do inc+dec together.
- Buttons other than btn_mode are ignored in SHOW and COMMIT.
- Reset values (reset low, asynchronous):
  - state SHOW.
  - shadow 0, cursor 7.
  - string 32'haaaa_aaaa.
  - count_8 5'd8.
  - edit 0, load 0, time_out 24'h0.

## Timing
- All outputs are registered.
- In SHOW, string reflects time_in with 1-cycle latency.
- A button pulse on cycle n is reflected in string, count_8 and edit at cycle n+1.
- Commit sequence: btn_mode in EDIT at cycle n → load = 1 during cycle n+1 only → SHOW from n+2.
- time_in changes during EDIT do not affect the shadow.
- Reset asserted mid-EDIT discards the shadow, and no load is issued.

## Configuration
- EDIT_TIMEOUT_EN defined:
  - A counter clears on any button pulse in EDIT.
  - When it reaches TIMEOUT_CYCLES−1, the state returns to SHOW without a load pulse. string resumes mirroring time_in on the next cycle.
  - btn_mode on the timeout cycle takes priority, and the FSM goes to COMMIT.
- Undefined: no counter logic is built, and EDIT persists indefinitely.

## Structure
- Shared package holds:
  - state encoding: SHOW, EDIT, COMMIT.
  - digit codes DIGIT_BLANK = 4'ha and DIGIT_DASH = 4'hb.
  - CURSOR_NONE = 5'd8.
  - per-position limit constants.
- One sub-module, bcd_digit_step: combinational; takes digit, limit, inc, dec and returns the next digit with wrap. It is instantiated once and muxed by cursor.

## Test plan
- Reset release, then time_in = 24'h123456 for 2 cycles → string = 32'h12b34b56, count_8 = 8, edit = 0, load = 0.
- Cursor walk: btn_mode, then btn_right ×6 → count_8 steps 7,6,4,3,1,0,7; btn_left ×1 → count_8 = 0.
- Hour limits: shadow 09:00:00, cursor 7:
  - btn_inc twice → H1 = 2, H0 forced to 3, string[31:24] = 8'h23.
  - btn_inc again → H1 = 0.
  - At cursor 6, btn_dec from H0 = 0 with H1 = 2 → H0 = 3.
- Commit: edit the shadow to 23:59:58, then btn_mode → exactly one load pulse with time_out = 24'h235958; edit = 0 two cycles after btn_mode.
- Priority and reset:
  - btn_mode + btn_inc in the same cycle in EDIT → COMMIT with the digit unchanged.
  - btn_inc + btn_dec together → no change.
  - reset asserted mid-EDIT → no load, outputs at reset values.
- EDIT_TIMEOUT_EN with TIMEOUT_CYCLES = 16:
  - 16 idle cycles in EDIT → SHOW, no load.
  - A btn_inc on cycle 10 restarts the count.

Source files
------------

// File: rtl/time_set_editor_pkg.sv
// Shared definitions for the time-set editor: FSM state encoding, special display
// digit codes, cursor constants, per-position digit limits and cursor/display helpers.
package time_set_editor_pkg;

  typedef enum logic [1:0] {
    StShow,
    StEdit,
    StCommit
  } state_e;

  localparam logic [3:0] DIGIT_BLANK = 4'ha;
  localparam logic [3:0] DIGIT_DASH  = 4'hb;

  localparam logic [4:0] CURSOR_NONE = 5'd8;
  localparam logic [4:0] CURSOR_HOME = 5'd7;

  // Upper bound of each editable digit; H0 drops to LIMIT_H0_20 when H1 is 2.
  localparam logic [3:0] LIMIT_H1    = 4'd2;
  localparam logic [3:0] LIMIT_H0    = 4'd9;
  localparam logic [3:0] LIMIT_H0_20 = 4'd3;
  localparam logic [3:0] LIMIT_M1    = 4'd5;
  localparam logic [3:0] LIMIT_M0    = 4'd9;
  localparam logic [3:0] LIMIT_S1    = 4'd5;
  localparam logic [3:0] LIMIT_S0    = 4'd9;

  // Cursor ring over the editable positions 7,6,4,3,1,0 (dash positions skipped).
  function automatic logic [4:0] cursor_right(input logic [4:0] cur);
    case (cur)
      5'd7:    return 5'd6;
      5'd6:    return 5'd4;
      5'd4:    return 5'd3;
      5'd3:    return 5'd1;
      5'd1:    return 5'd0;
      default: return 5'd7;
    endcase
  endfunction

  function automatic logic [4:0] cursor_left(input logic [4:0] cur);
    case (cur)
      5'd0:    return 5'd1;
      5'd1:    return 5'd3;
      5'd3:    return 5'd4;
      5'd4:    return 5'd6;
      5'd6:    return 5'd7;
      default: return 5'd0;
    endcase
  endfunction

  // {H1,H0,M1,M0,S1,S0} -> H1 H0 - M1 M0 - S1 S0
  function automatic logic [31:0] fmt_display(input logic [23:0] t);
    return {t[23:16], DIGIT_DASH, t[15:8], DIGIT_DASH, t[7:0]};
  endfunction

endpackage

// File: rtl/time_set_editor_bcd_digit_step.sv
// bcd_digit_step: combinational single-digit stepper with wrap-around.
// Ports: digit/limit (current value and its maximum), inc/dec (step requests),
// next (stepped digit; unchanged when neither or both requests are set).
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic [3:0] limit,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] next
);

  always_comb begin
    next = digit;
    if (inc && !dec) begin
      next = (digit >= limit) ? 4'd0 : digit + 4'd1;
    end else if (dec && !inc) begin
      next = (digit == 4'd0) ? limit : digit - 4'd1;
    end
  end

endmodule

// File: rtl/time_set_editor.sv
// time_set_editor: cursor-driven HH-MM-SS editor feeding the display scanner.
// SHOW mirrors time_in; EDIT steps a shadow copy digit by digit; COMMIT pulses load
// for one cycle with time_out = shadow.
// Ports: clk, reset (async, active low), btn_mode/left/right/inc/dec (1-cycle pulses),
// time_in (BCD {H1,H0,M1,M0,S1,S0}), disp_string (8 display nibbles, digit 7 in
// [31:28]), count_8 (cursor index, 8 = none), edit, load, time_out (committed time).
// Build option: define EDIT_TIMEOUT_EN to abort EDIT after TIMEOUT_CYCLES idle cycles.
module time_set_editor
  import time_set_editor_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] time_in,
  output logic [31:0] disp_string,
  output logic [4:0]  count_8,
  output logic        edit,
  output logic        load,
  output logic [23:0] time_out
);

  state_e      state_q, state_d;
  logic [23:0] shadow_q, shadow_d;
  logic [4:0]  cursor_q, cursor_d;
  logic [31:0] string_q, string_d;
  logic [4:0]  count_q, count_d;
  logic        edit_q, edit_d;
  logic        load_q, load_d;
  logic [23:0] time_out_q, time_out_d;

  logic [2:0]  slot;        // nibble index in shadow, 5 = H1 ... 0 = S0
  logic [3:0]  cur_digit;
  logic [3:0]  cur_limit;
  logic [3:0]  stepped;

  always_comb begin
    case (cursor_q)
      5'd7:    slot = 3'd5;
      5'd6:    slot = 3'd4;
      5'd4:    slot = 3'd3;
      5'd3:    slot = 3'd2;
      5'd1:    slot = 3'd1;
      default: slot = 3'd0;
    endcase
  end

  assign cur_digit = shadow_q[{slot, 2'b00} +: 4];

  always_comb begin
    case (slot)
      3'd5:    cur_limit = LIMIT_H1;
      3'd4:    cur_limit = (shadow_q[23:20] == LIMIT_H1) ? LIMIT_H0_20 : LIMIT_H0;
      3'd3:    cur_limit = LIMIT_M1;
      3'd2:    cur_limit = LIMIT_M0;
      3'd1:    cur_limit = LIMIT_S1;
      default: cur_limit = LIMIT_S0;
    endcase
  end

  bcd_digit_step u_step (
    .digit (cur_digit),
    .limit (cur_limit),
    .inc   (btn_inc),
    .dec   (btn_dec),
    .next  (stepped)
  );

`ifdef EDIT_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        any_btn;

  assign any_btn = btn_mode | btn_left | btn_right | btn_inc | btn_dec;

  always_comb begin
    idle_d = '0;
    if (state_q == StEdit && !any_btn) idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cursor_d = cursor_q;
    unique case (state_q)
      StShow: begin
        if (btn_mode) begin
          state_d  = StEdit;
          shadow_d = time_in;
          cursor_d = CURSOR_HOME;
        end
      end
      StEdit: begin
        if (btn_mode) begin
          state_d = StCommit;
        end else if (btn_left || btn_right) begin
          // Both directions at once cancel out.
          if (btn_left ^ btn_right) begin
            cursor_d = btn_right ? cursor_right(cursor_q) : cursor_left(cursor_q);
          end
        end else if (btn_inc ^ btn_dec) begin
          shadow_d[{slot, 2'b00} +: 4] = stepped;
          // Raising H1 to 2 may leave H0 out of range.
          if (shadow_d[23:20] == LIMIT_H1 && shadow_d[19:16] > LIMIT_H0_20) begin
            shadow_d[19:16] = LIMIT_H0_20;
          end
        end
`ifdef EDIT_TIMEOUT_EN
        else if (!(btn_inc || btn_dec) && idle_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = StShow;
        end
`endif
      end
      StCommit: state_d = StShow;
      default:  state_d = StShow;
    endcase
  end

  // Outputs are registered from next-state values so a pulse shows up one cycle later.
  always_comb begin
    string_d   = fmt_display(time_in);
    count_d    = CURSOR_NONE;
    edit_d     = 1'b0;
    load_d     = 1'b0;
    time_out_d = time_out_q;
    unique case (state_d)
      StShow: ;
      StEdit: begin
        string_d = fmt_display(shadow_d);
        count_d  = cursor_d;
        edit_d   = 1'b1;
      end
      StCommit: begin
        string_d   = fmt_display(shadow_d);
        load_d     = 1'b1;
        time_out_d = shadow_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StShow;
      shadow_q   <= '0;
      cursor_q   <= CURSOR_HOME;
      string_q   <= {8{DIGIT_BLANK}};
      count_q    <= CURSOR_NONE;
      edit_q     <= 1'b0;
      load_q     <= 1'b0;
      time_out_q <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cursor_q   <= cursor_d;
      string_q   <= string_d;
      count_q    <= count_d;
      edit_q     <= edit_d;
      load_q     <= load_d;
      time_out_q <= time_out_d;
    end
  end

  assign disp_string = string_q;
  assign count_8     = count_q;
  assign edit        = edit_q;
  assign load        = load_q;
  assign time_out    = time_out_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Scoreboard bench for time_set_editor: stimulus updates a digit-array reference model
// and queues the expected registered outputs; a monitor compares them every cycle.
module tb_time_set_editor;

  localparam logic [31:0] TimeoutCycles = 32'd16;
  localparam logic [4:0] BMode = 5'b10000;
  localparam logic [4:0] BL    = 5'b01000;
  localparam logic [4:0] BR    = 5'b00100;
  localparam logic [4:0] BInc  = 5'b00010;
  localparam logic [4:0] BDec  = 5'b00001;
  localparam logic [4:0] BNone = 5'b00000;

  typedef struct packed {
    logic [31:0] str;
    logic [4:0]  cnt;
    logic        edit;
    logic        load;
    logic [23:0] tout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_mode, btn_left, btn_right, btn_inc, btn_dec;
  logic [23:0] time_in;
  logic [31:0] disp_string;
  logic [4:0]  count_8;
  logic        edit, load;
  logic [23:0] time_out;

  always #5 clk = ~clk;

  time_set_editor #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .time_in     (time_in),
    .disp_string (disp_string),
    .count_8     (count_8),
    .edit        (edit),
    .load        (load),
    .time_out    (time_out)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = show, 1 = edit, 2 = commit.
  int          m_mode;
  int          m_dig[6];      // 5 = H1 ... 0 = S0
  int          m_pos_idx;     // index into positions[]
  int          m_idle;
  logic [23:0] m_tout;
  int          positions[6] = '{7, 6, 4, 3, 1, 0};
  int          tin_h, tin_m, tin_s;

  function automatic logic [23:0] tin_bcd();
    return {4'(tin_h / 10), 4'(tin_h % 10), 4'(tin_m / 10), 4'(tin_m % 10),
            4'(tin_s / 10), 4'(tin_s % 10)};
  endfunction

  function automatic logic [31:0] show_of(input logic [23:0] t);
    logic [31:0] s;
    s = {t[23:16], 4'hb, t[15:8], 4'hb, t[7:0]};
    return s;
  endfunction

  function automatic logic [23:0] shadow_bcd();
    return {4'(m_dig[5]), 4'(m_dig[4]), 4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]),
            4'(m_dig[0])};
  endfunction

  function automatic int limit_of(input int slot);
    case (slot)
      5:       return 2;
      4:       return (m_dig[5] == 2) ? 3 : 9;
      3, 1:    return 5;
      default: return 9;
    endcase
  endfunction

  task automatic model_step(input bit rst, input logic [4:0] b);
    exp_t e;
    int   slot, lim;
    bit   mode, l, r, inc, dec;
    {mode, l, r, inc, dec} = b;
    if (!rst) begin
      m_mode = 0; m_pos_idx = 0; m_idle = 0; m_tout = '0;
      foreach (m_dig[i]) m_dig[i] = 0;
      e = '{str: 32'haaaa_aaaa, cnt: 5'd8, edit: 1'b0, load: 1'b0, tout: 24'h0};
      exp_q.push_back(e);
      return;
    end
    case (m_mode)
      0: if (mode) begin
        m_mode = 1; m_pos_idx = 0; m_idle = 0;
        m_dig[5] = tin_h / 10; m_dig[4] = tin_h % 10;
        m_dig[3] = tin_m / 10; m_dig[2] = tin_m % 10;
        m_dig[1] = tin_s / 10; m_dig[0] = tin_s % 10;
      end
      1: begin
        if (mode) m_mode = 2;
        else if (l || r) begin
          if (l != r) m_pos_idx = r ? (m_pos_idx + 1) % 6 : (m_pos_idx + 5) % 6;
          m_idle = 0;
        end else if (inc || dec) begin
          if (inc != dec) begin
            slot = 5 - m_pos_idx;
            lim  = limit_of(slot);
            m_dig[slot] = inc ? (m_dig[slot] + 1) % (lim + 1)
                              : (m_dig[slot] + lim) % (lim + 1);
            if (m_dig[5] == 2 && m_dig[4] > 3) m_dig[4] = 3;
          end
          m_idle = 0;
        end else begin
`ifdef EDIT_TIMEOUT_EN
          if (m_idle == int'(TimeoutCycles) - 1) m_mode = 0;
          else m_idle++;
`endif
        end
      end
      default: m_mode = 0;
    endcase
    e.tout = m_tout;
    case (m_mode)
      0: e = '{str: show_of(tin_bcd()), cnt: 5'd8, edit: 1'b0, load: 1'b0, tout: m_tout};
      1: e = '{str: show_of(shadow_bcd()), cnt: 5'(positions[m_pos_idx]), edit: 1'b1,
               load: 1'b0, tout: m_tout};
      default: begin
        m_tout = shadow_bcd();
        e = '{str: show_of(shadow_bcd()), cnt: 5'd8, edit: 1'b0, load: 1'b1, tout: m_tout};
      end
    endcase
    exp_q.push_back(e);
  endtask

  // Reset is asynchronous: outputs must drop before any clock edge.
  task automatic check_reset_now();
    checks++;
    if ({disp_string, count_8, edit, load, time_out} !==
        {32'haaaa_aaaa, 5'd8, 1'b0, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL async_reset got str=%h cnt=%0d edit=%b load=%b tout=%h want reset values",
               disp_string, count_8, edit, load, time_out);
    end
  endtask

  // Called on a falling edge; applies one cycle of inputs.
  task automatic drive(input bit rst, input logic [4:0] b);
    reset   = rst;
    {btn_mode, btn_left, btn_right, btn_inc, btn_dec} = b;
    time_in = tin_bcd();
    model_step(rst, b);
    if (!rst) begin
      #1;
      check_reset_now();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, BNone);
  endtask

  task automatic set_tin(input int h, input int m, input int s);
    tin_h = h; tin_m = m; tin_s = s;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({disp_string, count_8, edit, load, time_out} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got str=%h cnt=%0d edit=%b load=%b tout=%h want str=%h cnt=%0d edit=%b load=%b tout=%h",
                   $time, disp_string, count_8, edit, load, time_out,
                   e.str, e.cnt, e.edit, e.load, e.tout);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    {btn_mode, btn_left, btn_right, btn_inc, btn_dec} = '0;
    set_tin(12, 34, 56);
    time_in = tin_bcd();
    @(negedge clk);
    drive(1'b0, BNone);
    drive(1'b0, BNone);
    idle(2);                                   // 12b34b56, no cursor

    drive(1'b1, BMode);                        // cursor walk
    for (int i = 0; i < 6; i++) drive(1'b1, BR);
    drive(1'b1, BL);
    drive(1'b1, BMode);
    idle(2);

    set_tin(9, 0, 0);                          // hour limits
    drive(1'b1, BMode);
    drive(1'b1, BInc); drive(1'b1, BInc); drive(1'b1, BInc);
    drive(1'b1, BInc); drive(1'b1, BInc);
    drive(1'b1, BR);
    drive(1'b1, BInc); drive(1'b1, BDec);
    drive(1'b1, BMode);
    idle(2);

    set_tin(23, 59, 57);                       // commit, shadow isolated from time_in
    drive(1'b1, BMode);
    set_tin(1, 2, 3);
    for (int i = 0; i < 5; i++) drive(1'b1, BR);
    drive(1'b1, BInc);
    drive(1'b1, BMode);
    idle(3);

    drive(1'b1, BMode);                        // priority
    drive(1'b1, BInc | BDec);
    drive(1'b1, BL | BR);
    drive(1'b1, BL | BInc);
    drive(1'b1, BMode | BInc);
    idle(2);

    drive(1'b1, BMode);                        // reset mid-edit
    drive(1'b1, BInc);
    drive(1'b0, BMode);
    drive(1'b0, BNone);
    idle(2);

`ifdef EDIT_TIMEOUT_EN
    drive(1'b1, BMode);
    idle(20);
    drive(1'b1, BMode);
    idle(9);
    drive(1'b1, BInc);
    idle(20);
`endif

    for (int n = 0; n < 800; n++) begin
      logic [4:0] b;
      if ($urandom_range(2, 0) == 0)
        set_tin($urandom_range(23, 0), $urandom_range(59, 0), $urandom_range(59, 0));
      b[4] = ($urandom_range(15, 0) == 0);
      b[3] = ($urandom_range(5, 0) == 0);
      b[2] = ($urandom_range(5, 0) == 0);
      b[1] = ($urandom_range(3, 0) == 0);
      b[0] = ($urandom_range(3, 0) == 0);
      drive(($urandom_range(199, 0) != 0), b);
    end
    idle(1);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
